// File: rtl/iic_recv.sv
// IIC write-only slave receiver: decodes START/chip/register/data/STOP frames
// from an oversampled bus and presents register writes on a simple strobe.
module iic_recv #(
    parameter logic [7:0] CHIP_ID = 8'hA0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl,
    input  logic       sda,
    output logic [7:0] reg_addr,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, CHIP, REG, DATA, WAIT_STOP} state_t;

    state_t     state, state_nxt;
    logic       scl_m, scl_s, scl_d;
    logic       sda_m, sda_s, sda_d;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       bit_pend, bit_pend_nxt;
    logic       first_data, first_data_nxt;
    logic [7:0] reg_addr_nxt, wr_data_nxt;
    logic       wr_valid_nxt, err_nxt;
    logic       scl_rise, scl_fall, start_det, stop_det, in_frame;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_m <= 1'b1;
            scl_s <= 1'b1;
            scl_d <= 1'b1;
            sda_m <= 1'b1;
            sda_s <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_m <= scl;
            scl_s <= scl_m;
            scl_d <= scl_s;
            sda_m <= sda;
            sda_s <= sda_m;
            sda_d <= sda_s;
        end
    end

    // scl_rise needs scl_d low while start/stop need it high, so they never coincide
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign in_frame  = (state == CHIP) || (state == REG) || (state == DATA);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            bit_pend   <= 1'b0;
            first_data <= 1'b0;
            reg_addr   <= 8'h00;
            wr_data    <= 8'h00;
            wr_valid   <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            bit_pend   <= bit_pend_nxt;
            first_data <= first_data_nxt;
            reg_addr   <= reg_addr_nxt;
            wr_data    <= wr_data_nxt;
            wr_valid   <= wr_valid_nxt;
            err        <= err_nxt;
        end
    end

    // A data bit is sampled on the scl rise but only counted on the following
    // fall, so the rise that precedes a STOP/repeated START after a full byte
    // leaves the counter at 0 and is not mistaken for a truncated byte.
    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        bit_pend_nxt   = bit_pend;
        first_data_nxt = first_data;
        reg_addr_nxt   = reg_addr;
        wr_data_nxt    = wr_data;
        wr_valid_nxt   = 1'b0;
        err_nxt        = 1'b0;

        if (start_det || stop_det) begin
            err_nxt      = in_frame && (bit_cnt != 4'd0);
            state_nxt    = start_det ? CHIP : IDLE;
            bit_cnt_nxt  = 4'd0;
            shreg_nxt    = 8'h00;
            bit_pend_nxt = 1'b0;
        end else if (in_frame) begin
            if (scl_rise) begin
                if (bit_cnt == 4'd8) begin
                    bit_cnt_nxt = 4'd0;
                    case (state)
                        CHIP: state_nxt = (shreg == CHIP_ID) ? REG : WAIT_STOP;
                        REG: begin
                            reg_addr_nxt   = shreg;
                            first_data_nxt = 1'b1;
                            state_nxt      = DATA;
                        end
                        DATA: begin
                            if (!first_data) begin
                                reg_addr_nxt = reg_addr + 8'd1;
                            end
                            first_data_nxt = 1'b0;
                            wr_data_nxt    = shreg;
                            wr_valid_nxt   = 1'b1;
                        end
                        default: state_nxt = state;
                    endcase
                end else begin
                    shreg_nxt    = {shreg[6:0], sda_s};
                    bit_pend_nxt = 1'b1;
                end
            end else if (scl_fall && bit_pend) begin
                bit_cnt_nxt  = bit_cnt + 4'd1;
                bit_pend_nxt = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iic_recv.sv
// Directed self-checking bench for iic_recv: bit-banged IIC frames with
// hand-computed expected writes, errors and busy levels.
module tb_iic_recv;

    logic       clk;
    logic       rstn;
    logic       scl;
    logic       sda;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int wv_n     = 0;
    int err_n    = 0;
    logic [7:0] wa [0:31];
    logic [7:0] wd [0:31];
    int wv_base;
    int err_base;

    iic_recv #(.CHIP_ID(8'hA0)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .scl      (scl),
        .sda      (sda),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe and error pulse, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_valid) begin
            if (wv_n < 32) begin
                wa[wv_n] = reg_addr;
                wd[wv_n] = wr_data;
            end
            wv_n = wv_n + 1;
        end
        if (err) err_n = err_n + 1;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic busStart();
        sda = 1'b0;
        waitClk(8);
        scl = 1'b0;
        waitClk(4);
    endtask

    task automatic busRestart();
        sda = 1'b1;
        waitClk(4);
        scl = 1'b1;
        waitClk(8);
        sda = 1'b0;
        waitClk(8);
        scl = 1'b0;
        waitClk(4);
    endtask

    task automatic busStop();
        sda = 1'b0;
        waitClk(4);
        scl = 1'b1;
        waitClk(8);
        sda = 1'b1;
        waitClk(12);
    endtask

    task automatic sendBit(input logic b);
        sda = b;
        waitClk(4);
        scl = 1'b1;
        waitClk(8);
        scl = 1'b0;
        waitClk(4);
    endtask

    task automatic sendBits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) sendBit(b[i]);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        sendBits(b, 8);
        sendBit(1'b0);
    endtask

    task automatic markCounts();
        wv_base  = wv_n;
        err_base = err_n;
    endtask

    initial begin
        rstn = 1'b0;
        scl  = 1'b1;
        sda  = 1'b1;
        waitClk(3);
        checkOutput("rst_reg_addr", {24'd0, reg_addr}, 32'h00);
        checkOutput("rst_wr_data", {24'd0, wr_data}, 32'h00);
        checkOutput("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        rstn = 1'b1;
        waitClk(4);

        $display("[TB] basic write A0/12/5A");
        markCounts();
        busStart();
        checkOutput("basic_busy_start", {31'd0, busy}, 32'd1);
        applyStimulus(8'hA0);
        applyStimulus(8'h12);
        applyStimulus(8'h5A);
        checkOutput("basic_busy_pre_stop", {31'd0, busy}, 32'd1);
        busStop();
        checkOutput("basic_wv_count", wv_n - wv_base, 32'd1);
        checkOutput("basic_addr", {24'd0, wa[wv_base]}, 32'h12);
        checkOutput("basic_data", {24'd0, wd[wv_base]}, 32'h5A);
        checkOutput("basic_err_count", err_n - err_base, 32'd0);
        checkOutput("basic_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("basic_addr_hold", {24'd0, reg_addr}, 32'h12);

        $display("[TB] chip mismatch A2");
        markCounts();
        busStart();
        applyStimulus(8'hA2);
        applyStimulus(8'h34);
        applyStimulus(8'h56);
        checkOutput("mis_busy_pre_stop", {31'd0, busy}, 32'd1);
        busStop();
        checkOutput("mis_wv_count", wv_n - wv_base, 32'd0);
        checkOutput("mis_err_count", err_n - err_base, 32'd0);
        checkOutput("mis_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("mis_data_hold", {24'd0, wr_data}, 32'h5A);

        $display("[TB] address wrap FF -> 00");
        markCounts();
        busStart();
        applyStimulus(8'hA0);
        applyStimulus(8'hFF);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        busStop();
        checkOutput("wrap_wv_count", wv_n - wv_base, 32'd2);
        checkOutput("wrap_addr0", {24'd0, wa[wv_base]}, 32'hFF);
        checkOutput("wrap_data0", {24'd0, wd[wv_base]}, 32'h01);
        checkOutput("wrap_addr1", {24'd0, wa[wv_base + 1]}, 32'h00);
        checkOutput("wrap_data1", {24'd0, wd[wv_base + 1]}, 32'h02);
        checkOutput("wrap_err_count", err_n - err_base, 32'd0);

        $display("[TB] stop in mid data byte");
        markCounts();
        busStart();
        applyStimulus(8'hA0);
        applyStimulus(8'h10);
        sendBits(8'hC5, 4);
        busStop();
        checkOutput("abort_err_count", err_n - err_base, 32'd1);
        checkOutput("abort_wv_count", wv_n - wv_base, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_addr_hold", {24'd0, reg_addr}, 32'h10);

        $display("[TB] repeated start in mid register byte");
        markCounts();
        busStart();
        applyStimulus(8'hA0);
        sendBits(8'hE0, 3);
        busRestart();
        checkOutput("rs_busy", {31'd0, busy}, 32'd1);
        applyStimulus(8'hA0);
        applyStimulus(8'h20);
        applyStimulus(8'h33);
        busStop();
        checkOutput("rs_err_count", err_n - err_base, 32'd1);
        checkOutput("rs_wv_count", wv_n - wv_base, 32'd1);
        checkOutput("rs_addr", {24'd0, wa[wv_base]}, 32'h20);
        checkOutput("rs_data", {24'd0, wd[wv_base]}, 32'h33);

        $display("[TB] reset in mid data byte");
        markCounts();
        busStart();
        applyStimulus(8'hA0);
        applyStimulus(8'h44);
        sendBits(8'h9C, 4);
        rstn = 1'b0;
        #1;
        checkOutput("mrst_reg_addr", {24'd0, reg_addr}, 32'h00);
        checkOutput("mrst_wr_data", {24'd0, wr_data}, 32'h00);
        checkOutput("mrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mrst_err", {31'd0, err}, 32'd0);
        checkOutput("mrst_wr_valid", {31'd0, wr_valid}, 32'd0);
        waitClk(3);
        rstn = 1'b1;
        waitClk(4);
        sendBits(8'h0C, 4);
        sendBit(1'b0);
        busStop();
        checkOutput("mrst_tail_wv", wv_n - wv_base, 32'd0);
        checkOutput("mrst_tail_err", err_n - err_base, 32'd0);
        busStart();
        applyStimulus(8'hA0);
        applyStimulus(8'h7E);
        applyStimulus(8'hC3);
        busStop();
        checkOutput("mrst_next_wv", wv_n - wv_base, 32'd1);
        checkOutput("mrst_next_addr", {24'd0, wa[wv_base]}, 32'h7E);
        checkOutput("mrst_next_data", {24'd0, wd[wv_base]}, 32'hC3);
        checkOutput("mrst_next_err", err_n - err_base, 32'd0);
        checkOutput("mrst_next_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
